// File: rtl/datapath_sequencer.sv
// Command-driven sequencer for the CR16 datapath (register-file clear or ALU bursts of 1-16 writes).
// Optional abort support is compiled in when CR16_SEQ_ABORT_EN is defined.
module datapath_sequencer #(
  parameter int CLEAR_CYCLES = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_CMD_VALID,
  output logic                  O_CMD_READY,
  input  logic                  I_CMD_CLEAR,
  input  logic [3:0]            I_CMD_DEST,
  input  logic [3:0]            I_CMD_A,
  input  logic [3:0]            I_CMD_B,
  input  logic [DATA_WIDTH-1:0] I_CMD_IMMEDIATE,
  input  logic                  I_CMD_IMMEDIATE_SELECT,
  input  logic [3:0]            I_CMD_OPCODE,
  input  logic [3:0]            I_CMD_REPEAT,
  input  logic                  I_CMD_AUTO_INC,
  input  logic                  I_ABORT,
  input  logic [DATA_WIDTH-1:0] I_RESULT_BUS,
  input  logic [4:0]            I_STATUS_FLAGS,
  output logic                  O_DP_NRESET,
  output logic [15:0]           O_REG_WRITE_ENABLE,
  output logic [3:0]            O_REG_A_SELECT,
  output logic [3:0]            O_REG_B_SELECT,
  output logic [DATA_WIDTH-1:0] O_IMMEDIATE,
  output logic                  O_IMMEDIATE_SELECT,
  output logic [3:0]            O_OPCODE,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_ABORTED,
  output logic [DATA_WIDTH-1:0] O_LAST_RESULT,
  output logic [4:0]            O_LAST_FLAGS
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int CNT_W = (CLR_W > 4) ? CLR_W : 4;
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'd1 << idx;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            dest_q, dest_d;
  logic                  auto_inc_q, auto_inc_d;
  logic                  ready_q, ready_d;
  logic                  dp_nreset_q, dp_nreset_d;
  logic [15:0]           we_q, we_d;
  logic [3:0]            a_sel_q, a_sel_d;
  logic [3:0]            b_sel_q, b_sel_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  imm_sel_q, imm_sel_d;
  logic [3:0]            opcode_q, opcode_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [DATA_WIDTH-1:0] last_result_q, last_result_d;
  logic [4:0]            last_flags_q, last_flags_d;
  logic                  abort_s;
  logic [3:0]            inc_s;

`ifdef CR16_SEQ_ABORT_EN
  assign abort_s = I_ABORT;
`else
  logic unused_abort_s;
  assign unused_abort_s = I_ABORT;
  assign abort_s        = 1'b0;
`endif

  assign inc_s = {3'b000, auto_inc_q};

  // Next-state and next-output computation; control outputs default to idle (zero).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dest_d        = dest_q;
    auto_inc_d    = auto_inc_q;
    ready_d       = 1'b0;
    dp_nreset_d   = 1'b1;
    we_d          = 16'd0;
    a_sel_d       = 4'd0;
    b_sel_d       = 4'd0;
    imm_d         = {DATA_WIDTH{1'b0}};
    imm_sel_d     = 1'b0;
    opcode_d      = 4'd0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    last_result_d = last_result_q;
    last_flags_d  = last_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (I_CMD_VALID && ready_q) begin
          if (I_CMD_CLEAR) begin
            state_d     = ST_CLEAR;
            cnt_d       = CLR_LOAD;
            dp_nreset_d = 1'b0;
          end else begin
            state_d    = ST_EXEC;
            cnt_d      = CNT_W'(I_CMD_REPEAT);
            dest_d     = I_CMD_DEST;
            auto_inc_d = I_CMD_AUTO_INC;
            we_d       = onehot16(I_CMD_DEST);
            a_sel_d    = I_CMD_A;
            b_sel_d    = I_CMD_B;
            imm_d      = I_CMD_IMMEDIATE;
            imm_sel_d  = I_CMD_IMMEDIATE_SELECT;
            opcode_d   = I_CMD_OPCODE;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if ((cnt_q == {CNT_W{1'b0}}) || abort_s) begin
          state_d       = ST_DONE;
          done_d        = 1'b1;
          aborted_d     = abort_s;
          last_result_d = {DATA_WIDTH{1'b0}};
          last_flags_d  = 5'd0;
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          dp_nreset_d = 1'b0;
        end
      end
      ST_EXEC: begin
        // The write in this cycle always completes; its result is captured on the way out.
        if ((cnt_q == {CNT_W{1'b0}}) || abort_s) begin
          state_d       = ST_DONE;
          done_d        = 1'b1;
          aborted_d     = abort_s;
          last_result_d = I_RESULT_BUS;
          last_flags_d  = I_STATUS_FLAGS;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          dest_d    = dest_q + inc_s;
          we_d      = onehot16(dest_q + inc_s);
          a_sel_d   = a_sel_q + inc_s;
          b_sel_d   = b_sel_q + inc_s;
          imm_d     = imm_q;
          imm_sel_d = imm_sel_q;
          opcode_d  = opcode_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; the datapath is held in reset while I_NRESET is low.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      dest_q        <= 4'd0;
      auto_inc_q    <= 1'b0;
      ready_q       <= 1'b0;
      dp_nreset_q   <= 1'b0;
      we_q          <= 16'd0;
      a_sel_q       <= 4'd0;
      b_sel_q       <= 4'd0;
      imm_q         <= {DATA_WIDTH{1'b0}};
      imm_sel_q     <= 1'b0;
      opcode_q      <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      last_result_q <= {DATA_WIDTH{1'b0}};
      last_flags_q  <= 5'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dest_q        <= dest_d;
      auto_inc_q    <= auto_inc_d;
      ready_q       <= ready_d;
      dp_nreset_q   <= dp_nreset_d;
      we_q          <= we_d;
      a_sel_q       <= a_sel_d;
      b_sel_q       <= b_sel_d;
      imm_q         <= imm_d;
      imm_sel_q     <= imm_sel_d;
      opcode_q      <= opcode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      last_result_q <= last_result_d;
      last_flags_q  <= last_flags_d;
    end
  end

  assign O_CMD_READY        = ready_q;
  assign O_DP_NRESET        = dp_nreset_q;
  assign O_REG_WRITE_ENABLE = we_q;
  assign O_REG_A_SELECT     = a_sel_q;
  assign O_REG_B_SELECT     = b_sel_q;
  assign O_IMMEDIATE        = imm_q;
  assign O_IMMEDIATE_SELECT = imm_sel_q;
  assign O_OPCODE           = opcode_q;
  assign O_BUSY             = busy_q;
  assign O_DONE             = done_q;
  assign O_ABORTED          = aborted_q;
  assign O_LAST_RESULT      = last_result_q;
  assign O_LAST_FLAGS       = last_flags_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small register-file/ALU model closing the loop.
// Abort scenario depends on CR16_SEQ_ABORT_EN.
module tb_datapath_sequencer;
  localparam int DW = 16;

  logic          I_CLK = 1'b0;
  logic          I_NRESET = 1'b0;
  logic          I_CMD_VALID = 1'b0;
  logic          I_CMD_CLEAR = 1'b0;
  logic [3:0]    I_CMD_DEST = 4'd0;
  logic [3:0]    I_CMD_A = 4'd0;
  logic [3:0]    I_CMD_B = 4'd0;
  logic [DW-1:0] I_CMD_IMMEDIATE = 16'd0;
  logic          I_CMD_IMMEDIATE_SELECT = 1'b0;
  logic [3:0]    I_CMD_OPCODE = 4'd0;
  logic [3:0]    I_CMD_REPEAT = 4'd0;
  logic          I_CMD_AUTO_INC = 1'b0;
  logic          I_ABORT = 1'b0;
  logic [DW-1:0] I_RESULT_BUS;
  logic [4:0]    I_STATUS_FLAGS;
  logic          O_CMD_READY, O_DP_NRESET, O_IMMEDIATE_SELECT, O_BUSY, O_DONE, O_ABORTED;
  logic [15:0]   O_REG_WRITE_ENABLE;
  logic [3:0]    O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE;
  logic [DW-1:0] O_IMMEDIATE, O_LAST_RESULT;
  logic [4:0]    O_LAST_FLAGS;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  datapath_sequencer #(.CLEAR_CYCLES(2), .DATA_WIDTH(DW)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
    .I_CMD_CLEAR(I_CMD_CLEAR), .I_CMD_DEST(I_CMD_DEST), .I_CMD_A(I_CMD_A), .I_CMD_B(I_CMD_B),
    .I_CMD_IMMEDIATE(I_CMD_IMMEDIATE), .I_CMD_IMMEDIATE_SELECT(I_CMD_IMMEDIATE_SELECT),
    .I_CMD_OPCODE(I_CMD_OPCODE), .I_CMD_REPEAT(I_CMD_REPEAT), .I_CMD_AUTO_INC(I_CMD_AUTO_INC),
    .I_ABORT(I_ABORT), .I_RESULT_BUS(I_RESULT_BUS), .I_STATUS_FLAGS(I_STATUS_FLAGS),
    .O_DP_NRESET(O_DP_NRESET), .O_REG_WRITE_ENABLE(O_REG_WRITE_ENABLE),
    .O_REG_A_SELECT(O_REG_A_SELECT), .O_REG_B_SELECT(O_REG_B_SELECT), .O_IMMEDIATE(O_IMMEDIATE),
    .O_IMMEDIATE_SELECT(O_IMMEDIATE_SELECT), .O_OPCODE(O_OPCODE), .O_BUSY(O_BUSY),
    .O_DONE(O_DONE), .O_ABORTED(O_ABORTED), .O_LAST_RESULT(O_LAST_RESULT),
    .O_LAST_FLAGS(O_LAST_FLAGS)
  );

  always #5 I_CLK = ~I_CLK;

  // Datapath model: 16-entry register file, op 0 = add, op 1 = sub, others pass A.
  logic [DW-1:0] rf [16];
  logic [DW-1:0] opb_s, res_s;
  logic [DW:0]   sum_s;
  always_comb begin
    opb_s = O_IMMEDIATE_SELECT ? O_IMMEDIATE : rf[O_REG_B_SELECT];
    case (O_OPCODE)
      4'd0:    sum_s = {1'b0, rf[O_REG_A_SELECT]} + {1'b0, opb_s};
      4'd1:    sum_s = {1'b0, rf[O_REG_A_SELECT]} - {1'b0, opb_s};
      default: sum_s = {1'b0, rf[O_REG_A_SELECT]};
    endcase
    res_s = sum_s[DW-1:0];
  end
  assign I_RESULT_BUS   = res_s;
  assign I_STATUS_FLAGS = {1'b0, ^res_s, res_s[DW-1], sum_s[DW], (res_s == 16'd0)};

  always @(posedge I_CLK) begin
    for (int i = 0; i < 16; i++) begin
      if (!O_DP_NRESET) rf[i] <= 16'd0;
      else if (O_REG_WRITE_ENABLE[i]) rf[i] <= res_s;
    end
  end

  always @(negedge I_CLK) begin
    if (O_REG_WRITE_ENABLE != 16'd0) wr_cnt = wr_cnt + 1;
    if (O_DONE) done_cnt = done_cnt + 1;
  end

  wire [70:0] all_outs_s = {O_CMD_READY, O_DP_NRESET, O_REG_WRITE_ENABLE, O_REG_A_SELECT,
                            O_REG_B_SELECT, O_IMMEDIATE, O_IMMEDIATE_SELECT, O_OPCODE, O_BUSY,
                            O_DONE, O_ABORTED, O_LAST_RESULT, O_LAST_FLAGS};

  // Present a command, wait (bounded) for ready, and return one cycle after the accepting edge.
  task automatic issue_cmd(input logic clr, input logic [3:0] dest, input logic [3:0] a,
                           input logic [3:0] b, input logic [DW-1:0] imm, input logic isel,
                           input logic [3:0] op, input logic [3:0] rep, input logic ainc,
                           output logic acc);
    int n;
    I_CMD_CLEAR = clr; I_CMD_DEST = dest; I_CMD_A = a; I_CMD_B = b;
    I_CMD_IMMEDIATE = imm; I_CMD_IMMEDIATE_SELECT = isel; I_CMD_OPCODE = op;
    I_CMD_REPEAT = rep; I_CMD_AUTO_INC = ainc; I_CMD_VALID = 1'b1;
    n = 0;
    while (!O_CMD_READY && n < 200) begin
      @(posedge I_CLK); #1; n++;
    end
    acc = O_CMD_READY;
    @(posedge I_CLK); #1;
    I_CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!O_DONE && cyc < 100) begin
      @(posedge I_CLK); #1; cyc++;
    end
  endtask

  task automatic test_reset;
    I_NRESET = 1'b0;
    repeat (3) @(posedge I_CLK);
    #1;
    checks++;
    if (all_outs_s !== 71'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", all_outs_s);
    end
    #2 I_NRESET = 1'b1;
    @(posedge I_CLK); #1;
    checks++;
    if ({O_CMD_READY, O_DP_NRESET, O_BUSY} !== 3'b110) begin
      errors++; $display("FAIL reset_release ready/dp/busy got=%b exp=110", {O_CMD_READY, O_DP_NRESET, O_BUSY});
    end
  endtask

  task automatic test_fibonacci;
    logic acc;
    int cyc, d0;
    logic [15:0] exp_r [6];
    logic [15:0] we_seen [6];
    exp_r = '{16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21};
    d0 = done_cnt;
    issue_cmd(1'b1, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 1'b0, acc);
    wait_done(cyc);
    @(posedge I_CLK); #1;
    issue_cmd(1'b0, 4'd0, 4'd0, 4'd0, 16'd1, 1'b1, 4'd0, 4'd0, 1'b0, acc);
    checks++;
    if (O_REG_WRITE_ENABLE !== 16'h0001) begin
      errors++; $display("FAIL fib_r0_we got=%h exp=0001", O_REG_WRITE_ENABLE);
    end
    wait_done(cyc);
    @(posedge I_CLK); #1;
    // r1 = r1 + 1 so that r0 = r1 = 1 seed the sequence
    issue_cmd(1'b0, 4'd1, 4'd1, 4'd0, 16'd1, 1'b1, 4'd0, 4'd0, 1'b0, acc);
    wait_done(cyc);
    @(posedge I_CLK); #1;
    issue_cmd(1'b0, 4'd2, 4'd0, 4'd1, 16'd0, 1'b0, 4'd0, 4'd5, 1'b1, acc);
    for (int i = 0; i < 6; i++) begin
      we_seen[i] = O_REG_WRITE_ENABLE;
      @(posedge I_CLK); #1;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (we_seen[i] !== (16'h0004 << i)) begin
        errors++; $display("FAIL fib_we[%0d] got=%h exp=%h", i, we_seen[i], 16'h0004 << i);
      end
    end
    checks++;
    if ({O_DONE, O_LAST_RESULT, O_LAST_FLAGS} !== {1'b1, 16'h0015, 5'h08}) begin
      errors++; $display("FAIL fib_done_result got=%b/%h/%h exp=1/0015/08", O_DONE, O_LAST_RESULT, O_LAST_FLAGS);
    end
    @(posedge I_CLK); #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rf[i+2] !== exp_r[i]) begin
        errors++; $display("FAIL fib_r%0d got=%0d exp=%0d", i + 2, rf[i+2], exp_r[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 4) begin
      errors++; $display("FAIL fib_done_count got=%0d exp=4", done_cnt - d0);
    end
  endtask

  task automatic test_wrap;
    logic acc;
    int cyc;
    logic [15:0] exp_we [3];
    logic [3:0]  exp_a [3];
    logic [3:0]  exp_b [3];
    exp_we = '{16'h8000, 16'h0001, 16'h0002};
    exp_a  = '{4'd15, 4'd0, 4'd1};
    exp_b  = '{4'd14, 4'd15, 4'd0};
    issue_cmd(1'b0, 4'd15, 4'd15, 4'd14, 16'd0, 1'b0, 4'd0, 4'd2, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT} !== {exp_we[i], exp_a[i], exp_b[i]}) begin
        errors++; $display("FAIL wrap[%0d] we/a/b got=%h/%0d/%0d exp=%h/%0d/%0d", i,
                           O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT, exp_we[i], exp_a[i], exp_b[i]);
      end
      @(posedge I_CLK); #1;
    end
    checks++;
    if (O_DONE !== 1'b1) begin
      errors++; $display("FAIL wrap_done got=%b exp=1", O_DONE);
    end
    @(posedge I_CLK); #1;
  endtask

  task automatic test_back_to_back;
    logic acc;
    int cyc, n, w0, d0;
    logic [15:0] we_seen [4];
    w0 = wr_cnt; d0 = done_cnt;
    issue_cmd(1'b0, 4'd3, 4'd0, 4'd0, 16'd2, 1'b1, 4'd0, 4'd3, 1'b0, acc);
    // second command waits on valid while the 4-write burst runs with changed fields
    I_CMD_DEST = 4'd9; I_CMD_A = 4'd0; I_CMD_IMMEDIATE = 16'd5; I_CMD_REPEAT = 4'd1;
    I_CMD_VALID = 1'b1;
    n = 0;
    while (!O_CMD_READY && n < 50) begin
      if (n < 4) we_seen[n] = O_REG_WRITE_ENABLE;
      n++;
      @(posedge I_CLK); #1;
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL b2b_ready_low_cycles got=%0d exp=5", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (we_seen[i] !== 16'h0008) begin
        errors++; $display("FAIL b2b_first_we[%0d] got=%h exp=0008", i, we_seen[i]);
      end
    end
    @(posedge I_CLK); #1;
    I_CMD_VALID = 1'b0;
    checks++;
    if ({O_CMD_READY, O_REG_WRITE_ENABLE} !== {1'b0, 16'h0200}) begin
      errors++; $display("FAIL b2b_second_we got=%b/%h exp=0/0200", O_CMD_READY, O_REG_WRITE_ENABLE);
    end
    wait_done(cyc);
    @(posedge I_CLK); #1;
    repeat (3) @(posedge I_CLK);
    #1;
    checks++;
    if ({wr_cnt - w0, done_cnt - d0} !== {32'd6, 32'd2}) begin
      errors++; $display("FAIL b2b_counts writes/dones got=%0d/%0d exp=6/2", wr_cnt - w0, done_cnt - d0);
    end
    checks++;
    if ({rf[3], rf[9]} !== {16'd3, 16'd6}) begin
      errors++; $display("FAIL b2b_regs r3/r9 got=%0d/%0d exp=3/6", rf[3], rf[9]);
    end
  endtask

  task automatic test_clear;
    logic acc;
    logic [2:0] dp_seen;
    logic [2:0] done_seen;
    logic [15:0] we_or;
    issue_cmd(1'b1, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 1'b0, acc);
    we_or = 16'd0;
    for (int i = 0; i < 3; i++) begin
      dp_seen[i] = O_DP_NRESET;
      done_seen[i] = O_DONE;
      we_or = we_or | O_REG_WRITE_ENABLE;
      if (i < 2) begin
        @(posedge I_CLK); #1;
      end
    end
    checks++;
    if ({dp_seen, done_seen} !== {3'b100, 3'b100}) begin
      errors++; $display("FAIL clear_timing dp(c3..c1)/done got=%b/%b exp=100/100", dp_seen, done_seen);
    end
    checks++;
    if ({we_or, O_LAST_RESULT, O_LAST_FLAGS} !== 37'd0) begin
      errors++; $display("FAIL clear_we_last got=%h/%h/%h exp=0/0/0", we_or, O_LAST_RESULT, O_LAST_FLAGS);
    end
    checks++;
    if ({rf[3], rf[9]} !== 32'd0) begin
      errors++; $display("FAIL clear_regs r3/r9 got=%0d/%0d exp=0/0", rf[3], rf[9]);
    end
    @(posedge I_CLK); #1;
  endtask

  task automatic test_reset_mid_burst;
    logic acc;
    int w0, wr_at_rst;
    logic [15:0] we_or;
    w0 = wr_cnt;
    issue_cmd(1'b0, 4'd0, 4'd0, 4'd0, 16'd3, 1'b1, 4'd0, 4'd15, 1'b1, acc);
    @(posedge I_CLK); #1;
    @(posedge I_CLK); #1;
    checks++;
    if (O_REG_WRITE_ENABLE !== 16'h0004) begin
      errors++; $display("FAIL rstmid_third_we got=%h exp=0004", O_REG_WRITE_ENABLE);
    end
    I_NRESET = 1'b0;
    #1;
    checks++;
    if (all_outs_s !== 71'd0) begin
      errors++; $display("FAIL rstmid_outputs got=%h exp=0", all_outs_s);
    end
    wr_at_rst = wr_cnt;
    repeat (2) @(posedge I_CLK);
    #3 I_NRESET = 1'b1;
    @(posedge I_CLK); #1;
    checks++;
    if ({O_CMD_READY, O_DP_NRESET, O_BUSY} !== 3'b110) begin
      errors++; $display("FAIL rstmid_release got=%b exp=110", {O_CMD_READY, O_DP_NRESET, O_BUSY});
    end
    we_or = 16'd0;
    repeat (5) begin
      we_or = we_or | O_REG_WRITE_ENABLE;
      @(posedge I_CLK); #1;
    end
    checks++;
    if ({we_or, 32'(wr_cnt - w0), 32'(wr_at_rst - w0)} !== {16'd0, 32'd2, 32'd2}) begin
      errors++; $display("FAIL rstmid_residual we/writes got=%h/%0d exp=0000/2", we_or, wr_cnt - w0);
    end
  endtask

`ifdef CR16_SEQ_ABORT_EN
  task automatic test_abort;
    logic acc;
    int w0;
    w0 = wr_cnt;
    issue_cmd(1'b0, 4'd4, 4'd3, 4'd0, 16'd7, 1'b1, 4'd0, 4'd7, 1'b1, acc);
    @(posedge I_CLK); #1;
    I_ABORT = 1'b1;
    @(posedge I_CLK); #1;
    I_ABORT = 1'b0;
    checks++;
    if ({O_DONE, O_ABORTED, O_LAST_RESULT} !== {1'b1, 1'b1, 16'd14}) begin
      errors++; $display("FAIL abort_done got=%b/%b/%0d exp=1/1/14", O_DONE, O_ABORTED, O_LAST_RESULT);
    end
    @(posedge I_CLK); #1;
    checks++;
    if ({O_CMD_READY, O_ABORTED, 32'(wr_cnt - w0)} !== {1'b1, 1'b0, 32'd2}) begin
      errors++; $display("FAIL abort_after ready/aborted/writes got=%b/%b/%0d exp=1/0/2", O_CMD_READY, O_ABORTED, wr_cnt - w0);
    end
  endtask
`else
  task automatic test_abort;
    logic acc;
    int w0, cyc;
    w0 = wr_cnt;
    issue_cmd(1'b0, 4'd4, 4'd3, 4'd0, 16'd7, 1'b1, 4'd0, 4'd7, 1'b1, acc);
    @(posedge I_CLK); #1;
    I_ABORT = 1'b1;
    @(posedge I_CLK); #1;
    I_ABORT = 1'b0;
    wait_done(cyc);
    checks++;
    if ({O_DONE, O_ABORTED, O_LAST_RESULT} !== {1'b1, 1'b0, 16'd56}) begin
      errors++; $display("FAIL abort_ignored got=%b/%b/%0d exp=1/0/56", O_DONE, O_ABORTED, O_LAST_RESULT);
    end
    @(posedge I_CLK); #1;
    checks++;
    if (wr_cnt - w0 !== 8) begin
      errors++; $display("FAIL abort_ignored_writes got=%0d exp=8", wr_cnt - w0);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fibonacci;
    test_wrap;
    test_back_to_back;
    test_clear;
    test_reset_mid_burst;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
